// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART divisor default and FSM state encoding
package uart_pkg;

    localparam int BAUD_CNT_MAX_DEF = 10416;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and status pulses out
interface uart_rx_if;
    import uart_pkg::*;

    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       frame_err;

    modport master (input rs232_rx, output rx_data, output po_flag, output frame_err);
    modport slave  (output rs232_rx, input rx_data, input po_flag, input frame_err);

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer plus history flop, falling-edge detect
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic sync_meta;
    logic rx_hist;

    // Flops reset high so a line idling high after reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
            rx_hist   <= 1'b1;
        end else begin
            sync_meta <= rs232_rx;
            rx_sync   <= sync_meta;
            rx_hist   <= rx_sync;
        end
    end

    assign rx_fall = rx_hist & ~rx_sync;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 transmitter sharing the receiver's divisor and state encoding
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_trig,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int               CNT_W    = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_state_e      state;
    uart_state_e      state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (state != IDLE) && (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        tx_busy   = 1'b1;
        case (state)
            IDLE: begin
                tx_busy = 1'b0;
                if (tx_trig) state_nxt = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                tx = shreg[bit_idx];
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + CNT_ONE;

            if (state == START)                          bit_idx <= 3'd0;
            else if (state == DATA && bit_end && bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;

            if (state == IDLE && tx_trig) shreg <= tx_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: mid-bit sampling, byte strobe and framing-error pulse
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT_MAX = BAUD_CNT_MAX_DEF,
    parameter int BAUD_CNT_MID = BAUD_CNT_MAX / 2
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    localparam int               CNT_W    = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MID);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_state_e      state;
    uart_state_e      state_nxt;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_sync;
    logic             rx_fall;
    logic             strobe;
    logic             load_byte;
    logic             bad_stop;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (bus.rs232_rx),
        .rx_sync  (rx_sync),
        .rx_fall  (rx_fall)
    );

    assign strobe = (state != IDLE) && (baud_cnt == CNT_MID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // STOP returns straight to IDLE at the stop-bit strobe, leaving half a bit to catch the next start edge.
    always_comb begin
        state_nxt = state;
        load_byte = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) state_nxt = START;
            end
            START: begin
                if (strobe) state_nxt = rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (strobe && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (strobe) begin
                    state_nxt = IDLE;
                    load_byte = rx_sync;
                    bad_stop  = ~rx_sync;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt      <= '0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            bus.rx_data   <= 8'h00;
            bus.po_flag   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            if (state == IDLE || baud_cnt == CNT_LAST) baud_cnt <= '0;
            else                                       baud_cnt <= baud_cnt + CNT_ONE;

            if (state == START && strobe) begin
                bit_idx <= 3'd0;
            end else if (state == DATA && strobe && bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == DATA && strobe) shreg[bit_idx] <= rx_sync;

            if (load_byte) bus.rx_data <= shreg;
            bus.po_flag   <= load_byte;
            bus.frame_err <= bad_stop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed frames against a frame-level expectation queue
module tb_uart_rx;

    localparam int MAX = 16;
    localparam int MID = 8;
    localparam int LAT = 2 + 1 + 9 * MAX + MID + 1;

    typedef struct {
        bit         fe;
        logic [7:0] data;
        int         exp_cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic       use_tx = 1'b0;
    logic       tx_trig = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_line;
    logic       tx_busy;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_err = 0;
    int         po_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] last_good = 8'h00;
    ev_t        exp_q[$];

    uart_rx_if bus ();

    assign bus.rs232_rx = use_tx ? tx_line : line;

    uart_rx #(.BAUD_CNT_MAX(MAX), .BAUD_CNT_MID(MID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    uart_tx #(.BAUD_CNT_MAX(MAX)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_trig (tx_trig),
        .tx_data (tx_data),
        .tx      (tx_line),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected byte or framing error, due LAT cycles after the start edge is put on the line.
    task automatic expect_frame(input logic [7:0] b, input logic stop, input int start_cyc);
        ev_t ev;
        ev.fe      = ~stop;
        ev.data    = b;
        ev.exp_cyc = start_cyc + LAT;
        exp_q.push_back(ev);
    endtask

    // Called at a negedge; returns at the negedge where the next frame could begin.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        if (abort_bit < 0) expect_frame(b, stop, cyc);
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (MAX / 2) @(negedge clk);
                rst_n = 1'b0;
                line  = 1'b1;
                exp_q.delete();
                last_good = 8'h00;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat (MAX) @(negedge clk);
        end
    endtask

    task automatic check_counts(input string name, input int po0, input int fe0, input int dpo, input int dfe);
        check({name, "_po_count"}, po_cnt - po0, dpo);
        check({name, "_fe_count"}, fe_cnt - fe0, dfe);
    endtask

    initial begin : compare
        ev_t ev;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus.po_flag) po_cnt++;
                if (bus.frame_err) fe_cnt++;
                if (bus.po_flag || bus.frame_err) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_pulse: po_flag=%0b frame_err=%0b required none (cycle %0d)",
                                 bus.po_flag, bus.frame_err, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        check("pulse_frame_err", bus.frame_err, ev.fe);
                        check("pulse_po_flag", bus.po_flag, !ev.fe);
                        n_checks++;
                        if (cyc < ev.exp_cyc - 1 || cyc > ev.exp_cyc + 1) begin
                            n_err++;
                            $display("FAIL pulse_latency: at cycle %0d required %0d +/-1", cyc, ev.exp_cyc);
                        end
                        if (!ev.fe) begin
                            check("rx_data_on_po", bus.rx_data, ev.data);
                            last_good = ev.data;
                        end
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].exp_cyc + 1) begin
                    ev = exp_q.pop_front();
                    n_checks++;
                    n_err++;
                    $display("FAIL missing_pulse: none by cycle %0d required at %0d (fe=%0b data=%0h)",
                             cyc, ev.exp_cyc, ev.fe, ev.data);
                end
                check("rx_data_hold", bus.rx_data, last_good);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int po0;
        int fe0;

        repeat (10) @(negedge clk);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_po_flag", bus.po_flag, 1'b0);
        check("reset_frame_err", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        po0 = po_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("t55_rx_data", bus.rx_data, 8'h55);
        check_counts("t55", po0, fe0, 1, 0);

        po0 = po_cnt; fe0 = fe_cnt;
        use_tx  = 1'b1;
        tx_data = 8'hA3;
        tx_trig = 1'b1;
        expect_frame(8'hA3, 1'b1, cyc + 1);
        @(negedge clk);
        tx_trig = 1'b0;
        repeat (10 * MAX + 10) @(negedge clk);
        use_tx = 1'b0;
        check("loop_rx_data", bus.rx_data, 8'hA3);
        check_counts("loop", po0, fe0, 1, 0);

        po0 = po_cnt; fe0 = fe_cnt;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("b2b_rx_data", bus.rx_data, 8'hFF);
        check_counts("b2b", po0, fe0, 2, 0);

        po0 = po_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1);
        repeat (2 * MAX) @(negedge clk);
        line = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_rx_data", bus.rx_data, 8'hFF);
        check_counts("ferr", po0, fe0, 0, 1);

        po0 = po_cnt; fe0 = fe_cnt;
        line = 1'b0;
        repeat (4) @(negedge clk);
        line = 1'b1;
        repeat (9) @(negedge clk);
        send_frame(8'h81, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("glitch_rx_data", bus.rx_data, 8'h81);
        check_counts("glitch", po0, fe0, 1, 0);

        po0 = po_cnt; fe0 = fe_cnt;
        send_frame(8'h96, 1'b1, 4);
        repeat (2 * MAX) @(negedge clk);
        check("abort_rx_data", bus.rx_data, 8'h00);
        check_counts("abort", po0, fe0, 0, 0);
        send_frame(8'h5A, 1'b1, -1);
        repeat (20) @(negedge clk);
        check("t5a_rx_data", bus.rx_data, 8'h5A);
        check_counts("t5a", po0, fe0, 1, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_CNT_MAX, default 10416, clock cycles per bit (100 MHz / 9600 baud).
REQ-002 Parameter BAUD_CNT_MID, default BAUD_CNT_MAX/2, sample point within a bit.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rs232_rx  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-006 rx_data  output  8  last correctly received byte.
REQ-007 po_flag  output  1  one-cycle pulse: rx_data updated this cycle.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.

Function
REQ-009 rs232_rx SHALL pass through a 2-flop synchronizer plus one history flop before any use.
REQ-010 A falling edge is synchronized-history 1 followed by synchronized current 0; only a falling edge in IDLE SHALL start a frame.
REQ-011 States: IDLE, START, DATA, STOP; any other encoding SHALL return to IDLE next cycle.
REQ-012 A baud counter SHALL clear on frame start, count 0..BAUD_CNT_MAX-1, then wrap to 0; it SHALL hold at 0 in IDLE.
REQ-013 A sample strobe SHALL fire for one cycle when the baud counter equals BAUD_CNT_MID.
REQ-014 START: at the strobe, synchronized line 0 -> DATA with bit index 0; line 1 (glitch) -> IDLE, no outputs.
REQ-015 DATA: at each strobe, sampled bit SHALL shift into a shift register at position bit index (LSB first); after index 7, -> STOP.
REQ-016 Bit index SHALL be 3 bits and cleared on entry to DATA; no wrap beyond 7 is permitted.
REQ-017 STOP: at the strobe, line 1 -> rx_data loads the shift register and po_flag pulses in the next cycle; line 0 -> frame_err pulses in the next cycle and rx_data holds.
REQ-018 After the stop-bit strobe the FSM SHALL return to IDLE in the same transition, so a start edge half a bit later is accepted (back-to-back frames).
REQ-019 po_flag and frame_err SHALL never assert together and SHALL be exactly one cycle wide.
REQ-020 Falling edges seen outside IDLE SHALL be ignored.
REQ-021 A line held low after a framing error SHALL not start a new frame until a high then falling edge occurs.
REQ-022 Latency: po_flag SHALL assert 2 sync cycles + 1 edge cycle + 9*BAUD_CNT_MAX + BAUD_CNT_MID + 1 cycles after the start-bit falling edge on rs232_rx, within +/-1 cycle.

Reset
REQ-023 On rst_n low, asynchronously: state IDLE, baud counter 0, bit index 0, shift register 0, rx_data 8'h00, po_flag 0, frame_err 0, synchronizer and history flops 1.
REQ-024 Reset mid-frame SHALL abort the frame with no po_flag or frame_err; reception resumes on the first falling edge after release.

Structure
REQ-025 Baud divisor default and FSM state encoding SHALL live in a shared package uart_pkg, also used by uart_tx.
REQ-026 The synchronizer plus edge detector SHALL be a sub-module uart_rx_sync (outputs: rx_sync, rx_fall).
REQ-027 Total RTL SHALL be a single FSM, one baud counter, one bit counter, one shift register; no FIFO.

Verification (bench overrides BAUD_CNT_MAX=16, BAUD_CNT_MID=8, 10 ns clk)
REQ-028 Reset 100 ns, send 8'h55 with 8N1 timing -> one po_flag pulse, rx_data=8'h55, no frame_err.
REQ-029 Loopback: uart_tx driving uart_rx, tx_trig pulse with tx_data=8'hA3 -> po_flag once, rx_data=8'hA3.
REQ-030 Back-to-back 8'h00 then 8'hFF, no idle gap -> two po_flag pulses, rx_data 8'h00 then 8'hFF.
REQ-031 Stop bit forced 0 on byte 8'h3C -> frame_err one pulse, no po_flag, rx_data keeps previous value.
REQ-032 Low glitch of 4 cycles on idle line -> no po_flag, no frame_err, FSM back in IDLE by cycle 9 after the glitch.
REQ-033 rst_n pulsed low during data bit 4 of 8'h96, then full 8'h5A sent -> no output for 8'h96, po_flag with rx_data=8'h5A.
